// File: rtl/ram_rank_pkg.sv
// Shared types for the rank controller: FSM state encoding and the accept rule.
package ram_rank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TURN   = 2'd2
  } state_t;

  // A new access may start from IDLE, or continue an ACTIVE stream on the same bank and direction.
  function automatic logic can_accept(state_t s, logic same_bank, logic same_dir);
    return (s == IDLE) || ((s == ACTIVE) && same_bank && same_dir);
  endfunction

endpackage

// File: rtl/ram_bank_sync.sv
// Single-port synchronous bank RAM; read data registered on a selected read cycle.
module ram_bank_sync #(
  parameter int unsigned WORD_DEPTH = 128,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned WORD_W = $clog2(WORD_DEPTH)
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  wr,
  input  logic [WORD_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [WORD_DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (wr) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_rank_ctrl.sv
// One memory rank: NUM_BANKS bank RAMs behind a valid/ready port with turnaround
// bubbles, per-bank chip select and a fixed two-edge read return pipeline.
module ram_rank_ctrl
  import ram_rank_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned WORD_DEPTH = 128,
  parameter int unsigned DATA_WIDTH = 8,
  localparam int unsigned BANK_W = $clog2(NUM_BANKS),
  localparam int unsigned WORD_W = $clog2(WORD_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rank_en,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [BANK_W+WORD_W-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [BANK_W-1:0]        rd_bank
);

  state_t                state;
  logic [BANK_W-1:0]     last_bank;
  logic                  last_wr;
  logic [BANK_W-1:0]     bank;
  logic [WORD_W-1:0]     word;
  logic                  accept;
  logic [NUM_BANKS-1:0]  cs;
  logic                  s1_valid;
  logic [BANK_W-1:0]     s1_bank;
  logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];

  assign bank = req_addr[BANK_W+WORD_W-1:WORD_W];
  assign word = req_addr[WORD_W-1:0];

  assign req_ready = !rst && rank_en && can_accept(state, bank == last_bank, req_wr == last_wr);
  assign accept    = req_valid && req_ready;

  // Only the addressed bank is selected, and only on an accepting cycle.
  always_comb begin
    cs = '0;
    if (accept) cs[bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_bank <= '0;
      last_wr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= ACTIVE;
            last_bank <= bank;
            last_wr   <= req_wr;
          end
        end
        ACTIVE: begin
          // A pending request that was refused here must be a bank or direction change.
          if (accept)                      state <= ACTIVE;
          else if (req_valid && rank_en)  state <= TURN;
          else                            state <= IDLE;
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 tracks which bank captured the word; stage 2 muxes it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_bank  <= '0;
    end else begin
      s1_valid <= accept && !req_wr;
      if (accept && !req_wr) s1_bank <= bank;
      rd_valid <= s1_valid;
      if (s1_valid) begin
        rd_data <= bank_dout[s1_bank];
        rd_bank <= s1_bank;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram_bank_sync #(
      .WORD_DEPTH(WORD_DEPTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk  (clk),
      .cs   (cs[b]),
      .wr   (req_wr),
      .addr (word),
      .din  (req_wdata),
      .dout (bank_dout[b])
    );
  end

endmodule
